// File: rtl/rggen_register_bus_initiator.sv
// Register bus initiator: one host request at a time, merges responder returns into one response.
// Latency: accept at T, bus valid at T+1, response valid at T+2 earliest (registered FSM outputs).
// Backpressure: o_host_ready low until the response handshake; response held until host takes it.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_host_*/o_host_ready     host request (valid/ready), access, address, write data, strobe
//   o_host_response_valid,
//   i_host_response_ready     host response handshake; o_host_status/o_host_read_data payload
//   o_register_*              latched request broadcast to all responders while busy
//   i_register_*              per-responder active/ready/status/read_data, packed by index
module rggen_register_bus_initiator #(
  parameter int                   ADDRESS_WIDTH  = 8,
  parameter int                   BUS_WIDTH      = 32,
  parameter int                   REGISTERS      = 1,
  parameter bit                   ERROR_STATUS   = 1'b0,
  parameter int                   TIMEOUT_CYCLES = 0,
  parameter logic [BUS_WIDTH-1:0] DEFAULT_DATA   = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_host_valid,
  output logic                           o_host_ready,
  input  logic [1:0]                     i_host_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_host_address,
  input  logic [BUS_WIDTH-1:0]           i_host_write_data,
  input  logic [BUS_WIDTH-1:0]           i_host_strobe,
  output logic                           o_host_response_valid,
  input  logic                           i_host_response_ready,
  output logic [1:0]                     o_host_status,
  output logic [BUS_WIDTH-1:0]           o_host_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  // Counter needs at least one bit even when the timeout is disabled.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RESPONSE = 2'd2
  } state_t;

  state_t                     state_q;
  logic                       host_ready_q;
  logic                       register_valid_q;
  logic                       response_valid_q;
  logic [1:0]                 access_q;
  logic [ADDRESS_WIDTH-1:0]   address_q;
  logic [BUS_WIDTH-1:0]       write_data_q;
  logic [BUS_WIDTH-1:0]       strobe_q;
  logic [1:0]                 status_q;
  logic [BUS_WIDTH-1:0]       read_data_q;
  logic [CW-1:0]              count_q;

  logic [1:0]                 hit_status;
  logic [BUS_WIDTH-1:0]       hit_data;
  logic                       any_hit;
  logic                       any_active;
  logic [CW-1:0]              count_inc;
  logic                       timeout;
  logic                       resolve;
  logic [1:0]                 status_d;
  logic [BUS_WIDTH-1:0]       read_data_d;

  always_comb begin
    hit_status = '0;
    hit_data   = '0;
    // Overlapping hits are a map error; they are simply OR-merged.
    for (int i = 0; i < REGISTERS; i++) begin
      if (i_register_active[i] && i_register_ready[i]) begin
        hit_status = hit_status | i_register_status[2*i +: 2];
        hit_data   = hit_data | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
      end
    end
    any_hit    = |(i_register_active & i_register_ready);
    any_active = |i_register_active;

    // Saturating: count_inc includes the current busy cycle.
    count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);
    timeout   = (TIMEOUT_CYCLES != 0) && (32'(count_inc) >= TIMEOUT_CYCLES);
    resolve   = any_hit || !any_active || timeout;

    // Precedence: hit, then unmapped, then timeout.
    if (any_hit) begin
      status_d    = hit_status;
      read_data_d = hit_data;
    end else if (!any_active) begin
      status_d    = {ERROR_STATUS, 1'b0};
      read_data_d = DEFAULT_DATA;
    end else begin
      status_d    = 2'b10;
      read_data_d = '0;
    end
    // access[0] set means a write (normal or posted); writes return no data.
    if (access_q[0]) begin
      read_data_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= IDLE;
      host_ready_q     <= 1'b1;
      register_valid_q <= 1'b0;
      response_valid_q <= 1'b0;
      access_q         <= '0;
      address_q        <= '0;
      write_data_q     <= '0;
      strobe_q         <= '0;
      status_q         <= '0;
      read_data_q      <= '0;
      count_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_host_valid) begin
            access_q         <= i_host_access;
            address_q        <= i_host_address;
            write_data_q     <= i_host_write_data;
            strobe_q         <= i_host_strobe;
            count_q          <= '0;
            host_ready_q     <= 1'b0;
            register_valid_q <= 1'b1;
            state_q          <= BUSY;
          end
        end
        BUSY: begin
          if (resolve) begin
            status_q         <= status_d;
            read_data_q      <= read_data_d;
            register_valid_q <= 1'b0;
            response_valid_q <= 1'b1;
            state_q          <= RESPONSE;
          end else begin
            count_q <= count_inc;
          end
        end
        RESPONSE: begin
          if (i_host_response_ready) begin
            response_valid_q <= 1'b0;
            host_ready_q     <= 1'b1;
            state_q          <= IDLE;
          end
        end
        default: begin
          state_q          <= IDLE;
          host_ready_q     <= 1'b1;
          register_valid_q <= 1'b0;
          response_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_host_ready          = host_ready_q;
  assign o_host_response_valid = response_valid_q;
  assign o_host_status         = status_q;
  assign o_host_read_data      = read_data_q;
  assign o_register_valid      = register_valid_q;
  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;

endmodule
